logic_operand_stage: RTL and testbench

Issue stage directly upstream of the 32-bit logical/shift unit in the execute path. Accepts decoded logical/shift instructions over a valid/ready handshake and selects the second operand (register or immediate). Applies write-back forwarding to its operands and buffers up to two instructions in a registered FIFO. Presents A, B and the 3-bit OpCode to the logical unit with a registered valid/ready output handshake.

---
 rtl/logic_operand_stage.sv | 140 ++++++++++++++
 tb/tb_logic_operand_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_operand_stage.sv
// Operand-select and two-entry issue buffer feeding the 32-bit logical/shift unit.
// Operands are captured with write-back forwarding and kept fresh while buffered.
module logic_operand_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rd_addr,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OpCode,
    output logic [4:0]  out_rd_addr
);

    localparam logic [1:0] Full = 2'(DEPTH);

    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] a_q [2];
    logic [31:0] a_d [2];
    logic [31:0] b_q [2];
    logic [31:0] b_d [2];
    logic [2:0]  op_q [2];
    logic [2:0]  op_d [2];
    logic [4:0]  rd_q [2];
    logic [4:0]  rd_d [2];
    logic [4:0]  rs1_q [2];
    logic [4:0]  rs1_d [2];
    logic [4:0]  rs2_q [2];
    logic [4:0]  rs2_d [2];
    logic [1:0]  use_imm_q, use_imm_d;

    logic        push, pop, fwd_en;
    logic [1:0]  entry_vld;
    logic [31:0] cap_a, cap_b;

    assign in_ready  = (count_q != Full);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign fwd_en    = wb_en & (wb_addr != 5'd0) & ~flush;

    assign entry_vld[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
    assign entry_vld[1] = (count_q == 2'd2) || ((count_q == 2'd1) && rd_ptr_q);

    always_comb begin
        cap_a = (fwd_en && (wb_addr == in_rs1_addr)) ? wb_data : in_rs1_val;
        if (in_use_imm) begin
            // Shifts only use the low five immediate bits as the shift amount.
            cap_b = (in_op[2:1] == 2'b11) ? {27'b0, in_imm[4:0]} : in_imm;
        end else begin
            cap_b = (fwd_en && (wb_addr == in_rs2_addr)) ? wb_data : in_rs2_val;
        end
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        count_d   = count_q + 2'(push) - 2'(pop);
        rd_ptr_d  = pop ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d  = push ? ~wr_ptr_q : wr_ptr_q;

        for (int i = 0; i < 2; i++) begin
            if (entry_vld[i] && fwd_en) begin
                if (rs1_q[i] == wb_addr) a_d[i] = wb_data;
                if (!use_imm_q[i] && (rs2_q[i] == wb_addr)) b_d[i] = wb_data;
            end
        end

        if (push) begin
            a_d[wr_ptr_q]       = cap_a;
            b_d[wr_ptr_q]       = cap_b;
            op_d[wr_ptr_q]      = in_op;
            rd_d[wr_ptr_q]      = in_rd_addr;
            rs1_d[wr_ptr_q]     = in_rs1_addr;
            rs2_d[wr_ptr_q]     = in_rs2_addr;
            use_imm_d[wr_ptr_q] = in_use_imm;
        end

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            a_q       <= '{default: '0};
            b_q       <= '{default: '0};
            op_q      <= '{default: '0};
            rd_q      <= '{default: '0};
            rs1_q     <= '{default: '0};
            rs2_q     <= '{default: '0};
            use_imm_q <= 2'b00;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
        end
    end

    // Head fields read as zero while the buffer is empty.
    assign A           = out_valid ? a_q[rd_ptr_q]  : 32'd0;
    assign B           = out_valid ? b_q[rd_ptr_q]  : 32'd0;
    assign OpCode      = out_valid ? op_q[rd_ptr_q] : 3'd0;
    assign out_rd_addr = out_valid ? rd_q[rd_ptr_q] : 5'd0;

endmodule

// File: tb/tb_logic_operand_stage.sv
// Bench for logic_operand_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of the issue buffer.
module tb_logic_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, wb_addr, out_rd_addr;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, wb_data, A, B;
    logic        in_use_imm, wb_en, out_valid, out_ready;
    logic [2:0]  in_op, OpCode;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
    } ent_t;

    ent_t mq[$];

    always #5 clk = ~clk;

    logic_operand_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
        .in_rd_addr(in_rd_addr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .OpCode(OpCode),
        .out_rd_addr(out_rd_addr)
    );

    // Model: the buffer is an ordered list of at most two instructions.
    task automatic model_step();
        ent_t e;
        bit   fwd, do_push, do_pop;
        if (!rst_n || flush) begin
            mq.delete();
            return;
        end
        fwd     = wb_en && (wb_addr != 0);
        do_push = in_valid && (mq.size() < 2);
        do_pop  = (mq.size() > 0) && out_ready;
        if (fwd) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e.rs1 == wb_addr) e.a = wb_data;
                if (!e.use_imm && e.rs2 == wb_addr) e.b = wb_data;
                mq[i] = e;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.a = (fwd && wb_addr == in_rs1_addr) ? wb_data : in_rs1_val;
            if (in_use_imm) e.b = (in_op >= 6) ? (in_imm % 32) : in_imm;
            else e.b = (fwd && wb_addr == in_rs2_addr) ? wb_data : in_rs2_val;
            e.op = in_op; e.rd = in_rd_addr; e.rs1 = in_rs1_addr; e.rs2 = in_rs2_addr;
            e.use_imm = in_use_imm;
            mq.push_back(e);
        end
    endtask

    // Inputs are set at a falling edge; this advances to the next falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic use_imm, input logic [31:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_op = op; in_rs1_addr = rs1; in_rs2_addr = rs2;
        in_rs1_val = v1; in_rs2_val = v2; in_use_imm = use_imm; in_imm = imm; in_rd_addr = rd;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_val = 0;
        in_rs2_val = 0; in_imm = 0; in_use_imm = 0; in_op = 0; in_rd_addr = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(3'd1, 5'd3, 5'd4, 32'h1111_0000, 32'h2222_0000, 1'b0, 32'h0, 5'd9);
        tick();
        set_instr(3'd4, 5'd6, 5'd8, 32'h3333_0000, 32'h4444_0000, 1'b0, 32'h0, 5'd10);
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_before_rst got %b want 0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        checks++; if ({A, B, OpCode, out_rd_addr} !== '0) begin
            errors++; $display("FAIL midrst_outs got A=%h B=%h op=%h rd=%h want 0", A, B, OpCode, out_rd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_instr(3'b010, 5'd1, 5'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h0, 5'd3);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (A !== 32'hF0F0_F0F0) begin errors++; $display("FAIL single_A got %h want f0f0f0f0", A); end
        checks++; if (B !== 32'h0FF0_0FF0) begin errors++; $display("FAIL single_B got %h want 0ff00ff0", B); end
        checks++; if (OpCode !== 3'b010) begin errors++; $display("FAIL single_op got %b want 010", OpCode); end
        checks++; if (out_rd_addr !== 5'd3) begin errors++; $display("FAIL single_rd got %0d want 3", out_rd_addr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_imm_shift();
        out_ready = 1'b1;
        set_instr(3'b110, 5'd1, 5'd2, 32'h8000_0001, 32'h5555_5555, 1'b1, 32'hFFFF_FFE3, 5'd4);
        tick();
        set_instr(3'b000, 5'd1, 5'd2, 32'h8000_0001, 32'h5555_5555, 1'b1, 32'hFFFF_FFE3, 5'd5);
        checks++; if (B !== 32'h0000_0003) begin errors++; $display("FAIL imm_shift_B got %h want 00000003", B); end
        checks++; if (OpCode !== 3'b110) begin errors++; $display("FAIL imm_shift_op got %b want 110", OpCode); end
        tick();
        in_valid = 1'b0;
        checks++; if (B !== 32'hFFFF_FFE3) begin errors++; $display("FAIL imm_and_B got %h want ffffffe3", B); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_instr(3'd3, 5'd1, 5'd2, 32'd1, 32'd11, 1'b0, 32'h0, 5'd1);
        tick();
        set_instr(3'd5, 5'd1, 5'd2, 32'd2, 32'd12, 1'b0, 32'h0, 5'd2);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        tick();
        set_instr(3'd7, 5'd1, 5'd2, 32'd3, 32'd13, 1'b0, 32'h0, 5'd3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", in_ready); end
        tick();
        checks++; if (A !== 32'd1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got A=%0d rdy=%b want A=1 rdy=0", A, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (A !== 32'd2 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_pop1 got A=%0d rdy=%b want A=2 rdy=1", A, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++; if (A !== 32'd3 || OpCode !== 3'd7) begin
            errors++; $display("FAIL bp_third got A=%0d op=%0d want A=3 op=7", A, OpCode);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_forwarding();
        out_ready = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
        set_instr(3'd2, 5'd5, 5'd7, 32'h0000_DEAD, 32'h0000_1111, 1'b0, 32'h0, 5'd6);
        tick();
        in_valid = 1'b0;
        checks++; if (A !== 32'h1234_5678) begin errors++; $display("FAIL fwd_cap_A got %h want 12345678", A); end
        wb_addr = 5'd7; wb_data = 32'hCAFE_BABE;
        checks++; if (B !== 32'h0000_1111) begin errors++; $display("FAIL fwd_pre_B got %h want 00001111", B); end
        tick();
        checks++; if (B !== 32'hCAFE_BABE) begin errors++; $display("FAIL fwd_buf_B got %h want cafebabe", B); end
        out_ready = 1'b1;
        wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        set_instr(3'd1, 5'd0, 5'd0, 32'h0000_AAAA, 32'h0000_BBBB, 1'b0, 32'h0, 5'd8);
        tick();
        checks++; if (A !== 32'h0000_AAAA || B !== 32'h0000_BBBB) begin
            errors++; $display("FAIL fwd_x0_cap got A=%h B=%h want 0000aaaa 0000bbbb", A, B);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        checks++; if (A !== 32'h0000_AAAA || B !== 32'h0000_BBBB) begin
            errors++; $display("FAIL fwd_x0_buf got A=%h B=%h want 0000aaaa 0000bbbb", A, B);
        end
        wb_en = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_instr(3'd0, 5'd1, 5'd2, 32'd100, 32'd200, 1'b0, 32'h0, 5'd1);
        tick();
        tick();
        set_instr(3'd6, 5'd1, 5'd2, 32'd999, 32'd888, 1'b0, 32'h0, 5'd31);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        ent_t        h;
        logic        exp_v;
        logic [31:0] exp_a, exp_b;
        logic [2:0]  exp_op;
        logic [4:0]  exp_rd;
        for (int n = 0; n < 600; n++) begin
            exp_v = (mq.size() > 0);
            h = exp_v ? mq[0] : '0;
            exp_a = h.a; exp_b = h.b; exp_op = h.op; exp_rd = h.rd;
            checks++; if (out_valid !== exp_v) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, out_valid, exp_v);
            end
            checks++; if (in_ready !== (mq.size() < 2)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", n, in_ready, mq.size() < 2);
            end
            checks++; if (A !== exp_a || B !== exp_b) begin
                errors++; $display("FAIL rnd_ab cyc %0d got %h %h want %h %h", n, A, B, exp_a, exp_b);
            end
            checks++; if (OpCode !== exp_op || out_rd_addr !== exp_rd) begin
                errors++; $display("FAIL rnd_oprd cyc %0d got %0d %0d want %0d %0d",
                                   n, OpCode, out_rd_addr, exp_op, exp_rd);
            end
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 29) == 0);
            in_op       = 3'($urandom);
            in_rs1_addr = 5'($urandom_range(0, 7));
            in_rs2_addr = 5'($urandom_range(0, 7));
            in_rd_addr  = 5'($urandom);
            in_rs1_val  = $urandom;
            in_rs2_val  = $urandom;
            in_imm      = $urandom;
            in_use_imm  = 1'($urandom);
            wb_en       = ($urandom_range(0, 9) < 5);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_imm_shift();
        test_back_to_back();
        test_forwarding();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
